// File: rtl/hazard_unit_param.sv
// Load-use stall and forwarding-select unit beside ID. The instruction in ID is checked
// against a shift-register history of the FWD_DEPTH instructions most recently issued to EX.

module hazard_slot_cmp (
  input  logic       vld,
  input  logic       wr,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use1,
  input  logic       use2,
  output logic       hit1,
  output logic       hit2
);
  // wr is already cleared for rd == x0, so x0 can never produce a hit
  assign hit1 = vld & wr & use1 & (rd == rs1);
  assign hit2 = vld & wr & use2 & (rd == rs2);
endmodule

module hazard_unit_param #(
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  parameter  int CNT_W     = 16,
  localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [CNT_W-1:0] stall_count
);
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  slot_t [FWD_DEPTH:1] hist_q, hist_d;
  logic  [CNT_W-1:0]   cnt_q, cnt_d;

  logic [6:0] opc;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       id_wr, id_use1, id_use2, id_ld;
  logic       unused_bits;

  assign opc         = id_inst[6:0];
  assign id_rd       = id_inst[11:7];
  assign id_rs1      = id_inst[19:15];
  assign id_rs2      = id_inst[24:20];
  assign unused_bits = ^{id_inst[31:25], id_inst[14:12]};

  always_comb begin
    id_wr   = 1'b0;
    id_use1 = 1'b0;
    id_use2 = 1'b0;
    id_ld   = 1'b0;
    case (opc)
      7'b0110011: begin id_wr = 1'b1; id_use1 = 1'b1; id_use2 = 1'b1; end
      7'b0010011: begin id_wr = 1'b1; id_use1 = 1'b1; end
      7'b0000011: begin id_wr = 1'b1; id_use1 = 1'b1; id_ld = 1'b1; end
      7'b0110111,
      7'b0010111,
      7'b1101111: id_wr = 1'b1;
      7'b1100111: begin id_wr = 1'b1; id_use1 = 1'b1; end
      7'b0100011,
      7'b1100011: begin id_use1 = 1'b1; id_use2 = 1'b1; end
      default: ;
    endcase
    if (id_rd == 5'd0) id_wr = 1'b0;
  end

  logic [FWD_DEPTH:1] hit1, hit2;

  for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_slot
    hazard_slot_cmp u_cmp (
      .vld  (hist_q[k].vld),
      .wr   (hist_q[k].wr),
      .rd   (hist_q[k].rd),
      .rs1  (id_rs1),
      .rs2  (id_rs2),
      .use1 (id_use1),
      .use2 (id_use2),
      .hit1 (hit1[k]),
      .hit2 (hit2[k])
    );
  end

  logic [SW-1:0] win1, win2;
  logic          haz1, haz2, fwd_ok;

  // Scan oldest to youngest so the youngest hit overwrites and therefore wins
  always_comb begin
    win1 = '0;
    win2 = '0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit1[k]) begin
        win1 = SW'(k);
        haz1 = hist_q[k].ld && (k <= LOAD_LAT);
      end
      if (hit2[k]) begin
        win2 = SW'(k);
        haz2 = hist_q[k].ld && (k <= LOAD_LAT);
      end
    end
  end

  assign stall    = id_valid & ~flush & (haz1 | haz2);
  assign fwd_ok   = id_valid & ~flush & ~stall;
  assign fwd_sel1 = fwd_ok ? win1 : '0;
  assign fwd_sel2 = fwd_ok ? win2 : '0;

  always_comb begin
    hist_d[1].vld = id_valid & ~stall & ~flush;
    hist_d[1].rd  = id_rd;
    hist_d[1].wr  = id_wr;
    hist_d[1].ld  = id_ld;
    for (int k = 2; k <= FWD_DEPTH; k++) hist_d[k] = hist_q[k-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised hazard-detection and forwarding-select unit for the in-order RISC-V pipeline.
- Sits beside ID. Decodes the instruction in ID against a shift-register history of the FWD_DEPTH most recent instructions issued to EX.
- Outputs are a load-use stall, per-operand forwarding source selects, and a saturating stall-cycle counter.
- Generalises the fixed two-deep EX/MEM scheme:
  - configurable history depth and load latency;
  - x0 filtering;
  - full per-opcode rd/rs usage decode;
  - flush handling.

Parameters:
FWD_DEPTH, 2, number of older in-flight instructions tracked (depth 1 = EX, 2 = MEM, ...); legal 2..7
LOAD_LAT, 1, extra cycles before a load result is forwardable; must be < FWD_DEPTH
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
id_valid  in  1  id_inst holds a real instruction
id_inst  in  32  instruction currently in ID
flush  in  1  branch/jump redirect: squash ID this cycle
stall  out  1  hold PC/IF/ID, inject bubble into EX
fwd_sel1  out  SW  rs1 source: 0 = regfile, k = result of history slot k; SW = clog2(FWD_DEPTH+1)
fwd_sel2  out  SW  rs2 source, same encoding
stall_count  out  CNT_W  cycles with stall=1 since reset, saturating

Behaviour:
- Decode, applied to id_inst and to each stored entry:
  - writes_rd for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and only when rd != 0.
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - is_load for 0000011.
  - Register 0 never matches.
- History: slots 1..FWD_DEPTH, each holding {valid, rd[4:0], writes_rd, is_load}.
  - On each rising edge, slot k+1 <= slot k.
  - Slot 1 <= ID entry if id_valid & ~stall & ~flush, else bubble (valid=0).
- Operand match: slot k matches rsN when valid, writes_rd, rd == rsN and uses_rsN.
  - Youngest match (smallest k) wins.
- stall, combinational:
  - 1 when id_valid & ~flush and the winning match for rs1 or rs2 is a load at k <= LOAD_LAT.
  - A youngest non-load match shadows an older load to the same register, so no stall.
- fwd_selN, combinational:
  - k of the winning match; 0 if there is no match or the operand is unused.
  - Forced to 0 while stall=1 or id_valid=0.
  - A load at k > LOAD_LAT is selectable.
- Load-use latency: with LOAD_LAT=L, a dependent instruction directly behind a load stalls exactly L cycles, then proceeds with fwd_sel = L+1.
- Flush:
  - Suppresses stall and forwarding in the same cycle.
  - ID is not recorded; older slots shift normally.
  - Flush has priority over stall.
- stall_count: increments on each rising edge where stall=1; holds at all-ones.
- Reset (rst=0, asynchronous): all slots invalid, stall_count=0. Outputs are therefore stall=0, fwd_sel1/2=0.
- Reset mid-stall: stall drops immediately, with no residual bubbles.
- Simultaneous matches on rs1 and rs2 to different slots are resolved independently.
- rs1 == rs2 gives identical selects.

Test Plan:
- Defaults. Issue add x5,x1,x2 then add x6,x5,x5 -> cycle 2: stall=0, fwd_sel1=1, fwd_sel2=1.
- Defaults. lw x7,0(x1) then sub x8,x7,x3 -> stall=1 for exactly 1 cycle, stall_count=1. Next cycle stall=0, fwd_sel1=2, fwd_sel2=0.
- LOAD_LAT=2, FWD_DEPTH=4. lw x9 then add x10,x9,x0 -> stall=1 for 2 cycles, then fwd_sel1=3.
- Writes to x0. addi x0,x0,1 then add x3,x0,x0 -> fwd_sel1=0, fwd_sel2=0, stall=0. sw x4,0(x9) after lw x4 -> stall=1 (rs2 use).
- Shadowing and flush:
  - addi x5 (slot 2) and lw x5 (slot 1), consumer in ID with flush=1 -> stall=0, selects 0.
  - Same case with lw x5 in slot 2 and addi x5 in slot 1 -> fwd_sel1=1, stall=0.
- Async reset. Assert rst=0 mid-stall between clock edges -> stall=0 and stall_count=0 immediately. After release, the first dependent instruction sees fwd_sel=0.
